// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared types and constants for the push-button debouncer
package pb_pkg;

  localparam int PB_DEBOUNCE_DEFAULT = 500000;

  typedef enum logic [1:0] {
    IDLE_LO   = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } pb_state_t;

endpackage

// File: rtl/pb_sync2.sv
// rtl/pb_sync2.sv - two-flop synchronizer with synchronous active-high reset
module pb_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous level through two flops; reset loads the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - push-button debouncer with registered level and edge pulses
module pb_debounce
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_raw,
  output logic pb_clean,
  output logic pb_rise,
  output logic pb_fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          pb_in;
  logic          pb_sync;
  pb_state_t     state;
  pb_state_t     state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          clean_nxt;

  // Fold the button polarity in before synchronization so 1 always means pressed.
  assign pb_in = ACTIVE_LOW ? ~pb_raw : pb_raw;

  pb_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pb_in),
    .q   (pb_sync)
  );

  // Next-state and run counter: cnt holds how many consecutive opposite samples have been seen.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE_LO: begin
        if (pb_sync) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!pb_sync) begin
          state_nxt = IDLE_LO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HI;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!pb_sync) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (pb_sync) begin
          state_nxt = STABLE_HI;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LO;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE_LO;
    endcase
  end

  assign clean_nxt = (state_nxt == STABLE_HI) || (state_nxt == WAIT_LO);

  // State, counter and outputs; outputs are computed from the next state so pb_clean tracks the state decode exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE_LO;
      cnt      <= '0;
      pb_clean <= 1'b0;
      pb_rise  <= 1'b0;
      pb_fall  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pb_clean <= clean_nxt;
      pb_rise  <= clean_nxt & ~pb_clean;
      pb_fall  <= ~clean_nxt & pb_clean;
    end
  end

endmodule

// File: tb/tb_pb_debounce.sv
// tb/tb_pb_debounce.sv - randomized self-checking bench for pb_debounce
module tb_pb_debounce;
  import pb_pkg::*;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pb_raw = 1'b0;
  logic pb_raw_n;
  logic pb_clean, pb_rise, pb_fall;
  logic pb_clean_n, pb_rise_n, pb_fall_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign pb_raw_n = ~pb_raw;

  pb_debounce #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut (
    .clk      (clk),
    .rst      (rst),
    .pb_raw   (pb_raw),
    .pb_clean (pb_clean),
    .pb_rise  (pb_rise),
    .pb_fall  (pb_fall)
  );

  pb_debounce #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut_n (
    .clk      (clk),
    .rst      (rst),
    .pb_raw   (pb_raw_n),
    .pb_clean (pb_clean_n),
    .pb_rise  (pb_rise_n),
    .pb_fall  (pb_fall_n)
  );

  // Reference model: the button level seen by the debouncer lags the pin by two
  // samples; the accepted level flips once D consecutive samples disagree with it.
  bit h1, h2, m_clean, m_rise, m_fall;
  int m_run;

  always @(posedge clk) begin
    bit seen;
    if (rst) begin
      h1 = 0; h2 = 0; m_clean = 0; m_rise = 0; m_fall = 0; m_run = 0;
    end else begin
      seen = h2;
      h2 = h1;
      h1 = pb_raw;
      m_rise = 0;
      m_fall = 0;
      if (seen != m_clean) begin
        m_run = m_run + 1;
        if (m_run == D) begin
          m_clean = ~m_clean;
          m_run = 0;
          m_rise = m_clean;
          m_fall = ~m_clean;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  logic [5:0] obs;
  logic [5:0] exp6;
  assign obs  = {pb_clean, pb_rise, pb_fall, pb_clean_n, pb_rise_n, pb_fall_n};
  assign exp6 = {m_clean, m_rise, m_fall, m_clean, m_rise, m_fall};

  task automatic apply_reset();
    rst = 1'b1;
    pb_raw = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int rise_edge = -1;
    int rises = 0;
    @(negedge clk);
    rst = 1'b1;
    pb_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold cycle=%0d got=%b want=000000", i, obs);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp6) begin
        errors++;
        $display("FAIL reset_model edge=%0d got=%b want=%b", e, obs, exp6);
      end
      if (pb_rise) begin
        rises++;
        if (rise_edge < 0) rise_edge = e;
      end
    end
    checks++;
    if (rise_edge !== D + 2 || rises !== 1) begin
      errors++;
      $display("FAIL reset_rise_edge got edge=%0d count=%0d want edge=%0d count=1", rise_edge, rises, D + 2);
    end
  endtask

  task automatic test_clean_press();
    int rise_edge = -1;
    int rises = 0;
    int falls = 0;
    apply_reset();
    pb_raw = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp6) begin
        errors++;
        $display("FAIL press_model edge=%0d got=%b want=%b", e, obs, exp6);
      end
      if (pb_rise) begin
        rises++;
        if (rise_edge < 0) rise_edge = e;
      end
      if (pb_fall) falls++;
      if (e == D + 1 || e == D + 2) begin
        checks++;
        if (pb_clean !== (e == D + 2)) begin
          errors++;
          $display("FAIL press_clean edge=%0d got=%b want=%b", e, pb_clean, (e == D + 2));
        end
      end
    end
    checks++;
    if (rise_edge !== D + 2 || rises !== 1 || falls !== 0) begin
      errors++;
      $display("FAIL press_pulses got edge=%0d rises=%0d falls=%0d want edge=%0d rises=1 falls=0",
               rise_edge, rises, falls, D + 2);
    end
  endtask

  task automatic test_bounce();
    bit pat[11] = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 1, 1};
    int rise_edge = -1;
    int rises = 0;
    apply_reset();
    for (int e = 1; e <= 20; e++) begin
      pb_raw = (e <= 11) ? pat[e-1] : 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== exp6) begin
        errors++;
        $display("FAIL bounce_model edge=%0d got=%b want=%b", e, obs, exp6);
      end
      if (pb_rise) begin
        rises++;
        if (rise_edge < 0) rise_edge = e;
      end
    end
    checks++;
    if (rise_edge !== 8 + D + 1 || rises !== 1) begin
      errors++;
      $display("FAIL bounce_rise got edge=%0d count=%0d want edge=%0d count=1", rise_edge, rises, 8 + D + 1);
    end
  endtask

  task automatic test_release();
    int fall_edge = -1;
    int falls = 0;
    apply_reset();
    pb_raw = 1'b1;
    repeat (10) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 8; i++) begin
        pb_raw = (i < 3) ? 1'b0 : 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== exp6 || pb_fall !== 1'b0 || pb_clean !== 1'b1) begin
          errors++;
          $display("FAIL glitch_model glitch=%0d i=%0d got=%b want=%b", g, i, obs, exp6);
        end
      end
    end
    pb_raw = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp6) begin
        errors++;
        $display("FAIL release_model edge=%0d got=%b want=%b", e, obs, exp6);
      end
      if (pb_fall) begin
        falls++;
        if (fall_edge < 0) fall_edge = e;
      end
    end
    checks++;
    if (fall_edge !== D + 2 || falls !== 1 || pb_clean !== 1'b0) begin
      errors++;
      $display("FAIL release_fall got edge=%0d count=%0d clean=%b want edge=%0d count=1 clean=0",
               fall_edge, falls, pb_clean, D + 2);
    end
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    apply_reset();
    pb_raw = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (dut.state == WAIT_HI && dut.cnt == 2) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrst_reach got=not_reached want=WAIT_HI_cnt2");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.state !== IDLE_LO || dut.cnt !== '0 || obs !== 6'b0) begin
      errors++;
      $display("FAIL midrst_state got state=%0d cnt=%0d out=%b want state=0 cnt=0 out=000000",
               dut.state, dut.cnt, obs);
    end
    rst = 1'b0;
    pb_raw = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      checks++;
      if (obs !== 6'b0 || obs !== exp6) begin
        errors++;
        $display("FAIL midrst_after edge=%0d got=%b want=000000", e, obs);
      end
    end
  endtask

  task automatic test_random_presses();
    int rises = 0, falls = 0, rises_n = 0, falls_n = 0;
    apply_reset();
    for (int p = 0; p < 20; p++) begin
      bit lvl = (p % 2 == 0);
      int nb = $urandom_range(0, 3);
      int nsteps = 0;
      bit seq[$];
      for (int b = 0; b < nb; b++) begin
        int a = $urandom_range(1, D - 1);
        int c = $urandom_range(1, D - 1);
        repeat (a) seq.push_back(lvl);
        repeat (c) seq.push_back(~lvl);
      end
      nsteps = D + 4 + $urandom_range(0, 5);
      repeat (nsteps) seq.push_back(lvl);
      foreach (seq[k]) begin
        pb_raw = seq[k];
        @(negedge clk);
        checks++;
        if (obs !== exp6 || (pb_rise && pb_fall) || (pb_rise_n && pb_fall_n)) begin
          errors++;
          $display("FAIL random_model phase=%0d k=%0d got=%b want=%b", p, k, obs, exp6);
        end
        rises += pb_rise;
        falls += pb_fall;
        rises_n += pb_rise_n;
        falls_n += pb_fall_n;
      end
    end
    checks++;
    if (rises !== 10 || falls !== 10 || rises_n !== 10 || falls_n !== 10) begin
      errors++;
      $display("FAIL random_counts got rise=%0d fall=%0d rise_n=%0d fall_n=%0d want 10 each",
               rises, falls, rises_n, falls_n);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_mid_reset();
    test_random_presses();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
